// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU op sequencer: ALU control codes and FSM state encoding.
// Pure declarations; no timing or flow-control behaviour of its own.
package alu_seq_pkg;

    localparam logic [3:0] ALU_OP_DIV  = 4'd0;
    localparam logic [3:0] ALU_OP_MUL  = 4'd1;
    localparam logic [3:0] ALU_OP_ADD  = 4'd2;
    localparam logic [3:0] ALU_OP_SUB  = 4'd3;
    localparam logic [3:0] ALU_OP_AND  = 4'd4;
    localparam logic [3:0] ALU_OP_OR   = 4'd5;
    localparam logic [3:0] ALU_OP_XOR  = 4'd6;
    localparam logic [3:0] ALU_OP_SHL  = 4'd7;
    localparam logic [3:0] ALU_OP_SHR  = 4'd8;
    localparam logic [3:0] ALU_OP_ROL  = 4'd9;
    localparam logic [3:0] ALU_OP_ROR  = 4'd10;
    localparam logic [3:0] ALU_OP_NOT  = 4'd11;
    localparam logic [3:0] ALU_OP_LAST = ALU_OP_NOT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } seq_state_e;

    // Only divide and multiply use the long settle window and return a high word.
    function automatic logic is_muldiv(input logic [3:0] op, input logic inc_pc);
        return !inc_pc && ((op == ALU_OP_DIV) || (op == ALU_OP_MUL));
    endfunction

endpackage

// File: rtl/alu_seq_wait_counter.sv
// Loadable down-counter timing the ALU settle window; done_o flags a count of 1.
// Load takes effect next cycle; no flow control, decrement saturates at zero.
module alu_seq_wait_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Holds one ALU request stable for its settle window, then returns z_high/z_low on a response channel.
// Latency: 2+W cycles legal, 1 cycle rejected; req_ready low until the response handshake completes.
// Optional ALU_SEQ_DIV_ZERO_CHECK_EN rejects divide-by-zero without issuing it to the ALU.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SIMPLE_WAIT = 1,
    parameter int MULDIV_WAIT = 4
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic        req_pc,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_reg1,
    output logic [31:0] alu_reg2,
    output logic [3:0]  alu_control,
    output logic        alu_inc_pc,
    input  logic [31:0] alu_z_high,
    input  logic [31:0] alu_z_low,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_hi,
    output logic [31:0] rsp_lo,
    output logic        rsp_err,
    output logic        busy
);

    localparam int MAX_WAIT = (MULDIV_WAIT > SIMPLE_WAIT) ? MULDIV_WAIT : SIMPLE_WAIT;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    seq_state_e       state_q;
    logic [31:0]      reg1_q, reg2_q, hi_q, lo_q;
    logic [3:0]       ctrl_q;
    logic             inc_pc_q, err_q, rdy_q, vld_q;

    logic             muldiv_d, illegal_d, div_zero_d, cnt_done;
    logic [CNT_W-1:0] cnt_load_d;
    logic [31:0]      cap_hi_d;

    always_comb begin
        muldiv_d   = is_muldiv(ctrl_q, inc_pc_q);
        cnt_load_d = muldiv_d ? CNT_W'(MULDIV_WAIT) : CNT_W'(SIMPLE_WAIT);
        cap_hi_d   = muldiv_d ? alu_z_high : 32'd0;
        illegal_d  = !req_pc && (req_op > ALU_OP_LAST);
`ifdef ALU_SEQ_DIV_ZERO_CHECK_EN
        div_zero_d = !req_pc && (req_op == ALU_OP_DIV) && (req_b == 32'd0);
`else
        div_zero_d = 1'b0;
`endif
    end

    alu_seq_wait_counter #(
        .CNT_W(CNT_W)
    ) u_wait_counter (
        .clk_i      (Clk),
        .clr_i      (Clr),
        .load_i     (state_q == ST_ISSUE),
        .load_val_i (cnt_load_d),
        .dec_i      (state_q == ST_WAIT),
        .done_o     (cnt_done)
    );

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q  <= ST_IDLE;
            reg1_q   <= '0;
            reg2_q   <= '0;
            ctrl_q   <= '0;
            inc_pc_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            err_q    <= 1'b0;
            rdy_q    <= 1'b1;
            vld_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        rdy_q <= 1'b0;
                        // Rejected requests never touch the ALU-facing registers.
                        if (div_zero_d) begin
                            state_q <= ST_RESP;
                            vld_q   <= 1'b1;
                            err_q   <= 1'b1;
                            hi_q    <= req_a;
                            lo_q    <= 32'hFFFF_FFFF;
                        end else if (illegal_d) begin
                            state_q <= ST_RESP;
                            vld_q   <= 1'b1;
                            err_q   <= 1'b1;
                            hi_q    <= '0;
                            lo_q    <= '0;
                        end else begin
                            state_q  <= ST_ISSUE;
                            reg1_q   <= req_a;
                            reg2_q   <= req_b;
                            ctrl_q   <= req_op;
                            inc_pc_q <= req_pc;
                        end
                    end
                end
                ST_ISSUE: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (cnt_done) begin
                        state_q <= ST_RESP;
                        vld_q   <= 1'b1;
                        err_q   <= 1'b0;
                        hi_q    <= cap_hi_d;
                        lo_q    <= alu_z_low;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q <= ST_IDLE;
                        vld_q   <= 1'b0;
                        rdy_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    vld_q   <= 1'b0;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready   = rdy_q;
    assign busy        = !rdy_q;
    assign rsp_valid   = vld_q;
    assign rsp_hi      = hi_q;
    assign rsp_lo      = lo_q;
    assign rsp_err     = err_q;
    assign alu_reg1    = reg1_q;
    assign alu_reg2    = reg2_q;
    assign alu_control = ctrl_q;
    assign alu_inc_pc  = inc_pc_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural ALU; table-driven vectors plus back-pressure and reset sequences.
module tb_alu_op_sequencer;

    logic        Clk = 1'b0;
    logic        Clr;
    logic        req_valid, req_ready, req_pc;
    logic [3:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [31:0] alu_reg1, alu_reg2, alu_z_high, alu_z_low;
    logic [3:0]  alu_control;
    logic        alu_inc_pc;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_hi, rsp_lo;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    alu_op_sequencer dut (
        .Clk(Clk), .Clr(Clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_pc(req_pc),
        .req_a(req_a), .req_b(req_b),
        .alu_reg1(alu_reg1), .alu_reg2(alu_reg2), .alu_control(alu_control), .alu_inc_pc(alu_inc_pc),
        .alu_z_high(alu_z_high), .alu_z_low(alu_z_low),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
        .rsp_err(rsp_err), .busy(busy)
    );

    // Behavioural ALU; the high word is deliberately garbage for single-word ops.
    logic [63:0] prod;
    always_comb begin
        prod       = {32'd0, alu_reg1} * {32'd0, alu_reg2};
        alu_z_high = 32'hA5A5_A5A5;
        alu_z_low  = 32'd0;
        if (alu_inc_pc) begin
            alu_z_low = alu_reg2 + 32'd1;
        end else begin
            case (alu_control)
                4'd0: begin
                    if (alu_reg2 == 32'd0) begin
                        alu_z_high = alu_reg1;
                        alu_z_low  = 32'hFFFF_FFFF;
                    end else begin
                        alu_z_high = alu_reg1 % alu_reg2;
                        alu_z_low  = alu_reg1 / alu_reg2;
                    end
                end
                4'd1: begin
                    alu_z_high = prod[63:32];
                    alu_z_low  = prod[31:0];
                end
                4'd2:  alu_z_low = alu_reg1 + alu_reg2;
                4'd3:  alu_z_low = alu_reg1 - alu_reg2;
                4'd4:  alu_z_low = alu_reg1 & alu_reg2;
                4'd5:  alu_z_low = alu_reg1 | alu_reg2;
                4'd6:  alu_z_low = alu_reg1 ^ alu_reg2;
                4'd7:  alu_z_low = alu_reg1 << alu_reg2[4:0];
                4'd8:  alu_z_low = alu_reg1 >> alu_reg2[4:0];
                4'd11: alu_z_low = ~alu_reg1;
                default: alu_z_low = 32'd0;
            endcase
        end
    end

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic        pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        err;
        int          lat;
        logic        issue;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    logic [31:0] exp_r1, exp_r2;
    logic [3:0]  exp_ctrl;
    logic        exp_inc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero_state(input string nm);
        chk({nm, ".req_ready"}, req_ready, 1);
        chk({nm, ".busy"}, busy, 0);
        chk({nm, ".rsp_valid"}, rsp_valid, 0);
        chk({nm, ".rsp_err"}, rsp_err, 0);
        chk({nm, ".rsp_hilo"}, {rsp_hi, rsp_lo}, 0);
        chk({nm, ".alu_regs"}, {alu_reg1, alu_reg2}, 0);
        chk({nm, ".alu_ctl"}, {alu_control, alu_inc_pc}, 0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where rsp_valid is seen.
    // lat counts rising edges from acceptance to the first edge that samples rsp_valid high.
    task automatic run_op(input logic [3:0] op, input logic pc, input logic [31:0] a,
                          input logic [31:0] b, output int lat, output logic unstable);
        logic [3:0]  c0;
        logic [31:0] r1, r2;
        logic        i0;
        chk("req_ready_before_req", req_ready, 1);
        req_op = op; req_pc = pc; req_a = a; req_b = b; req_valid = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        req_valid = 1'b0;
        lat = 1; unstable = 1'b0;
        c0 = alu_control; r1 = alu_reg1; r2 = alu_reg2; i0 = alu_inc_pc;
        while (!rsp_valid && lat < 64) begin
            @(negedge Clk);
            lat++;
            if (c0 !== alu_control || r1 !== alu_reg1 || r2 !== alu_reg2 || i0 !== alu_inc_pc)
                unstable = 1'b1;
        end
    endtask

    int   lat;
    logic unst;
    int   seen;

    initial begin
        vecs[0] = '{"add",     4'd2,  1'b0, 32'd5,       32'd7,       32'd0,   32'd12,      1'b0, 3, 1'b1};
        vecs[1] = '{"sub",     4'd3,  1'b0, 32'd10,      32'd3,       32'd0,   32'd7,       1'b0, 3, 1'b1};
        vecs[2] = '{"xor",     4'd6,  1'b0, 32'h0000F0F0, 32'h00000FF0, 32'd0,  32'h0000FF00, 1'b0, 3, 1'b1};
        vecs[3] = '{"shl",     4'd7,  1'b0, 32'd1,       32'd4,       32'd0,   32'd16,      1'b0, 3, 1'b1};
        vecs[4] = '{"mul",     4'd1,  1'b0, 32'h00010000, 32'h00010000, 32'd1, 32'd0,       1'b0, 6, 1'b1};
        vecs[5] = '{"div",     4'd0,  1'b0, 32'd100,     32'd7,       32'd2,   32'd14,      1'b0, 6, 1'b1};
        vecs[6] = '{"illegal", 4'd13, 1'b0, 32'd9,       32'd9,       32'd0,   32'd0,       1'b1, 1, 1'b0};
        vecs[7] = '{"pcinc",   4'd15, 1'b1, 32'd7,       32'd41,      32'd0,   32'd42,      1'b0, 3, 1'b1};
`ifdef ALU_SEQ_DIV_ZERO_CHECK_EN
        vecs[8] = '{"div0",    4'd0,  1'b0, 32'd100,     32'd0,       32'd100, 32'hFFFFFFFF, 1'b1, 1, 1'b0};
`else
        vecs[8] = '{"div0",    4'd0,  1'b0, 32'd100,     32'd0,       32'd100, 32'hFFFFFFFF, 1'b0, 6, 1'b1};
`endif

        Clr = 1'b1; req_valid = 1'b0; req_op = '0; req_pc = 1'b0; req_a = '0; req_b = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk_zero_state("reset");
        Clr = 1'b0;
        exp_r1 = '0; exp_r2 = '0; exp_ctrl = '0; exp_inc = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].pc, vecs[i].a, vecs[i].b, lat, unst);
            if (vecs[i].issue) begin
                exp_r1 = vecs[i].a; exp_r2 = vecs[i].b; exp_ctrl = vecs[i].op; exp_inc = vecs[i].pc;
            end
            chk({vecs[i].name, ".lat"}, lat, vecs[i].lat);
            chk({vecs[i].name, ".rsp_hi"}, rsp_hi, vecs[i].hi);
            chk({vecs[i].name, ".rsp_lo"}, rsp_lo, vecs[i].lo);
            chk({vecs[i].name, ".rsp_err"}, rsp_err, vecs[i].err);
            chk({vecs[i].name, ".req_ready_busy"}, {req_ready, busy}, 2'b01);
            chk({vecs[i].name, ".alu_stable"}, unst, 0);
            chk({vecs[i].name, ".alu_regs"}, {alu_reg1, alu_reg2}, {exp_r1, exp_r2});
            chk({vecs[i].name, ".alu_ctl"}, {alu_control, alu_inc_pc}, {exp_ctrl, exp_inc});
            @(posedge Clk);
            @(negedge Clk);
            chk({vecs[i].name, ".rsp_done"}, {rsp_valid, req_ready}, 2'b01);
        end

        // Back-pressure: response held for 3 cycles while a second request waits.
        rsp_ready = 1'b0;
        run_op(4'd2, 1'b0, 32'd1, 32'd2, lat, unst);
        chk("bp.first_lo", rsp_lo, 32'd3);
        req_op = 4'd3; req_pc = 1'b0; req_a = 32'd9; req_b = 32'd4; req_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge Clk);
            @(negedge Clk);
            chk("bp.hold", {rsp_valid, req_ready, rsp_lo}, {1'b1, 1'b0, 32'd3});
        end
        rsp_ready = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        chk("bp.after_hs", {rsp_valid, req_ready}, 2'b01);
        @(posedge Clk);
        @(negedge Clk);
        chk("bp.second_accepted", {busy, req_ready}, 2'b10);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 64) begin
            @(negedge Clk);
            lat++;
        end
        chk("bp.second_lat", lat, 3);
        chk("bp.second_lo", rsp_lo, 32'd5);
        @(posedge Clk);
        @(negedge Clk);

        // Reset during the WAIT of a multiply drops it silently.
        req_op = 4'd1; req_pc = 1'b0; req_a = 32'd3; req_b = 32'd5; req_valid = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        req_valid = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        chk("clr.in_flight", {busy, alu_control}, {1'b1, 4'd1});
        Clr = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Clr = 1'b0;
        chk_zero_state("clr");
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            if (rsp_valid) seen++;
        end
        chk("clr.no_rsp", seen, 0);
        run_op(4'd2, 1'b0, 32'd20, 32'd22, lat, unst);
        chk("clr.add_lat", lat, 3);
        chk("clr.add_res", {rsp_err, rsp_hi, rsp_lo}, {1'b0, 32'd0, 32'd42});
        @(posedge Clk);
        @(negedge Clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
